row_fifo_loader: RTL and testbench

- Write-side controller for the per-row input FIFOs that feed the systolic array.
- Accepts a valid/ready stream of row vectors, each ROW lanes of WIDTH bits.
- Writes every accepted vector into all ROW FIFOs in the same cycle, honouring the FIFO full flags.
- After a tile of i_len vectors has been written, pulses o_trigger to start the row read controller.

---
 rtl/row_fifo_loader.sv | 144 ++++++++++++++
 tb/tb_row_fifo_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/row_fifo_loader.sv
// row_fifo_loader: write-side controller for the per-row systolic input FIFOs.
// It accepts a valid/ready stream of ROW-lane vectors and writes each accepted
// vector into all ROW FIFOs on the same registered strobe. After i_len vectors
// have been written, it issues a one-cycle o_trigger that starts the row read
// controller.
module row_fifo_loader #(
  parameter int ROW   = 9,
  parameter int WIDTH = 9,
  parameter int LEN_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [LEN_W-1:0]       i_len,
  input  logic                   i_valid,
  input  logic [ROW*WIDTH-1:0]   i_data,
  output logic                   o_ready,
  input  logic [ROW-1:0]         i_fifo_full,
  output logic [ROW*WIDTH-1:0]   o_data,
  output logic [ROW-1:0]         o_write_enable,
  output logic                   o_busy,
  output logic [LEN_W-1:0]       o_count,
  output logic                   o_trigger
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;

  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       count_r;
  logic [ROW*WIDTH-1:0]   data_r;
  logic [ROW-1:0]         we_r;
  logic                   busy_r;
  logic                   trigger_r;

  logic                   ready_s;
  logic                   accept_s;
  logic                   last_s;
  logic                   any_full_s;

  // Handshake decode: one full row stalls every row, and nothing is accepted during reset.
  always_comb begin
    any_full_s = |i_fifo_full;
    ready_s    = 1'b0;
    if (i_rst) begin
      ready_s = 1'b0;
    end else if ((state_r == LOAD) && !any_full_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = i_valid & ready_s;
    last_s   = (count_r == (len_r - LEN_W'(1)));
  end

  // Next-state logic. A zero-length tile goes straight to DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start && (i_len != {LEN_W{1'b0}})) begin
          next_state_s = LOAD;
        end else if (i_start) begin
          next_state_s = DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = LOAD;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Tile length and vector counter. Both are latched and cleared only by a start that IDLE accepts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_r   <= {LEN_W{1'b0}};
      count_r <= {LEN_W{1'b0}};
    end else if ((state_r == IDLE) && i_start) begin
      len_r   <= i_len;
      count_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      count_r <= count_r + LEN_W'(1);
    end
  end

  // FIFO write port. The strobe follows the handshake by one cycle, and the data holds between writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_r <= {(ROW*WIDTH){1'b0}};
      we_r   <= {ROW{1'b0}};
    end else if (accept_s) begin
      data_r <= i_data;
      we_r   <= {ROW{1'b1}};
    end else begin
      we_r   <= {ROW{1'b0}};
    end
  end

  // Status flags are registered from the next state, so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_r    <= 1'b0;
      trigger_r <= 1'b0;
    end else begin
      busy_r    <= (next_state_s == LOAD) || (next_state_s == DONE);
      trigger_r <= (next_state_s == DONE);
    end
  end

  assign o_ready        = ready_s;
  assign o_data         = data_r;
  assign o_write_enable = we_r;
  assign o_busy         = busy_r;
  assign o_count        = count_r;
  assign o_trigger      = trigger_r;

endmodule

// File: tb/tb_row_fifo_loader.sv
// tb_row_fifo_loader: randomized plus directed bench for row_fifo_loader.
// A tile-level reference model tracks the remaining vectors per tile and
// predicts the handshake, strobes, count, busy and trigger. A scoreboard
// queue checks that written vectors arrive in order.
module tb_row_fifo_loader;

  localparam int ROW   = 9;
  localparam int WIDTH = 9;
  localparam int LEN_W = 8;
  localparam int DW    = ROW * WIDTH;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              valid;
  logic [DW-1:0]     data;
  logic              ready;
  logic [ROW-1:0]    full;
  logic [DW-1:0]     odata;
  logic [ROW-1:0]    we;
  logic              busy;
  logic [LEN_W-1:0]  count;
  logic              trigger;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed at tile level.
  bit              tile_active;
  int              remaining;
  logic [DW-1:0]   exp_data;
  logic            exp_we;
  logic [LEN_W-1:0] exp_count;
  logic            exp_busy;
  logic            exp_trigger;
  logic [DW-1:0]   sb_q[$];

  row_fifo_loader #(.ROW(ROW), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .i_valid(valid), .i_data(data), .o_ready(ready), .i_fifo_full(full),
    .o_data(odata), .o_write_enable(we), .o_busy(busy), .o_count(count),
    .o_trigger(trigger)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    v[31:0]    = $urandom;
    v[63:32]   = $urandom;
    v[DW-1:64] = 17'($urandom);
    return v;
  endfunction

  // One clock cycle: drive inputs, check ready, advance the model, then check the registered outputs.
  task automatic step(input logic s_rst, input logic s_start, input logic [LEN_W-1:0] s_len,
                      input logic s_valid, input logic [ROW-1:0] s_full);
    logic [DW-1:0] vec;
    logic          exp_ready;
    logic          acc;
    logic [DW-1:0] head;
    vec   = rand_vec();
    rst   = s_rst;
    start = s_start;
    len   = s_len;
    valid = s_valid;
    data  = vec;
    full  = s_full;
    #1;
    exp_ready = tile_active && (s_full == '0) && !s_rst;
    check_value("ready", 128'(ready), 128'(exp_ready));
    acc = exp_ready && s_valid;
    @(posedge clk);
    if (s_rst) begin
      tile_active = 1'b0; remaining = 0;
      exp_data = '0; exp_we = 1'b0; exp_count = '0; exp_busy = 1'b0; exp_trigger = 1'b0;
    end else if (exp_trigger) begin
      exp_we = 1'b0; exp_busy = 1'b0; exp_trigger = 1'b0;
    end else if (tile_active) begin
      if (acc) begin
        exp_we = 1'b1; exp_data = vec; exp_count = exp_count + 1'b1;
        sb_q.push_back(vec);
        remaining--;
        if (remaining == 0) begin
          tile_active = 1'b0; exp_trigger = 1'b1;
        end
      end else begin
        exp_we = 1'b0;
      end
    end else begin
      exp_we = 1'b0;
      if (s_start) begin
        exp_count = '0; exp_busy = 1'b1;
        if (s_len == 0) exp_trigger = 1'b1;
        else begin
          tile_active = 1'b1; remaining = int'(s_len);
        end
      end
    end
    #1;
    check_value("write_enable", 128'(we), exp_we ? 128'({ROW{1'b1}}) : 128'(0));
    check_value("data", 128'(odata), 128'(exp_data));
    check_value("count", 128'(count), 128'(exp_count));
    check_value("busy", 128'(busy), 128'(exp_busy));
    check_value("trigger", 128'(trigger), 128'(exp_trigger));
    if (we == {ROW{1'b1}}) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_write", 128'(1), 128'(0));
      end else begin
        head = sb_q.pop_front();
        check_value("write_order", 128'(odata), 128'(head));
      end
    end
  endtask

  initial begin
    tile_active = 1'b0; remaining = 0;
    exp_data = '0; exp_we = 1'b0; exp_count = '0; exp_busy = 1'b0; exp_trigger = 1'b0;
    rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; data = '0; full = '0;

    // Reset state.
    step(1'b1, 1'b0, 8'd0, 1'b0, 9'h000);
    step(1'b1, 1'b1, 8'd3, 1'b1, 9'h000);

    // Four-vector tile, continuous valid.
    step(1'b0, 1'b1, 8'd4, 1'b0, 9'h000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    check_value("len4_count", 128'(count), 128'd4);
    check_value("len4_trigger", 128'(trigger), 128'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);

    // Three-vector tile with a two-cycle stall on one row.
    step(1'b0, 1'b1, 8'd3, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h010);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h010);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);

    // Zero-length tile.
    step(1'b0, 1'b1, 8'd0, 1'b0, 9'h000);
    check_value("len0_trigger", 128'(trigger), 128'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);

    // Toggling valid with a two-vector tile.
    step(1'b0, 1'b1, 8'd2, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);

    // Reset after two of five vectors, then a one-vector tile.
    step(1'b0, 1'b1, 8'd5, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b1, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b1, 8'd1, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    check_value("len1_count", 128'(count), 128'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);

    // A start during LOAD is ignored.
    step(1'b0, 1'b1, 8'd3, 1'b0, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    step(1'b0, 1'b1, 8'd7, 1'b1, 9'h000);
    step(1'b0, 1'b0, 8'd0, 1'b1, 9'h000);
    check_value("ignored_start_trigger", 128'(trigger), 128'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic          r_rst;
      logic          r_start;
      logic [LEN_W-1:0] r_len;
      logic          r_valid;
      logic [ROW-1:0] r_full;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_start = ($urandom_range(0, 3) == 0);
      r_len   = ($urandom_range(0, 15) == 0) ? LEN_W'($urandom_range(0, 40))
                                             : LEN_W'($urandom_range(0, 6));
      r_valid = ($urandom_range(0, 3) != 0);
      r_full  = ($urandom_range(0, 4) == 0) ? (ROW'(1) << $urandom_range(0, ROW-1)) : '0;
      step(r_rst, r_start, r_len, r_valid, r_full);
    end
    step(1'b0, 1'b0, 8'd0, 1'b0, 9'h000);
    check_value("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
